chan_link_reset_sequencer: RTL and testbench
============================================

Name: chan_link_reset_sequencer

Overview:
Controller for one Aurora 8b10b channel link, running in the always-on clk50 domain. It sequences the GT reset and the system reset at startup and waits for channel_up within a timeout. When the link is lost, a hard error occurs, or the timeout expires, it retries with a holdoff and a bounded retry count. Its gt_reset_out and system_reset_out replace the direct clk50_reset drive of the Aurora support reset logic; its status goes to the channel I/O register block.

Parameters:
GT_RESET_CYCLES, 50, clk50 cycles gt_reset_out is held high per attempt (min 1)
SYS_RESET_CYCLES, 16, clk50 cycles system_reset_out is held high after gt_reset_out falls (min 1)
UP_TIMEOUT_CYCLES, 5000000, max cycles in WAIT_UP before declaring a failed attempt
HOLDOFF_CYCLES, 500000, idle cycles between a failure and the next attempt
MAX_RETRIES, 8, consecutive failed attempts before FAILED; 0 = unlimited
TIMER_W, 32, internal timer width; must hold the largest cycle parameter

Ports:
clk50  in  1  50 MHz free-running clock; all logic synchronous to it
clk50_reset  in  1  synchronous, active-high reset
enable  in  1  link enable (I/O register); low forces DISABLED
force_retry  in  1  single-cycle pulse; restarts the sequence from any state
channel_up  in  1  Aurora channel_up, user_clk domain, async here
lane_up  in  1  Aurora lane_up, async here
hard_err  in  1  Aurora hard_err, async here
soft_err  in  1  Aurora soft_err, async here
gt_reset_out  out  1  to support reset logic GT_RESET_IN
system_reset_out  out  1  to support reset logic RESET
link_ok  out  1  high only in LINK_UP
failed  out  1  high only in FAILED
fsm_state  out  3  encoded state, for status readback
retry_count  out  8  consecutive failed attempts, saturating at 255
drop_count  out  16  LINK_UP exits caused by a link drop or hard error, saturating
soft_err_count  out  16  synchronized soft_err rising edges, saturating

Behaviour:
- Async inputs: each passes through a 2-flop synchronizer. The FSM uses the synchronized versions only, so there are 2 cycles of input latency. soft_err is counted on the rising edge of its synchronized level.
- Reset (clk50_reset=1): state=GT_RST, timer=0, gt_reset_out=1, system_reset_out=1, link_ok=0, failed=0, all counters=0, synchronizer flops=0.
- States and encodings:
  - DISABLED=0
  - GT_RST=1
  - SYS_RST=2
  - WAIT_UP=3
  - LINK_UP=4
  - HOLDOFF=5
  - FAILED=6
- Outputs per state: gt_reset_out=1 in DISABLED, GT_RST, HOLDOFF and FAILED. system_reset_out=1 in every state except WAIT_UP and LINK_UP. Both outputs are registered.
- Timer: loads 0 on every state entry and increments while in a timed state.
- Priority each cycle, highest first:
  1. enable=0 -> DISABLED.
  2. force_retry=1 -> GT_RST and retry_count=0.
  3. Normal transitions.
- DISABLED: when enable=1 -> GT_RST; retry_count=0.
- GT_RST: when timer==GT_RESET_CYCLES-1 -> SYS_RST.
- SYS_RST: when timer==SYS_RESET_CYCLES-1 -> WAIT_UP.
- WAIT_UP:
  - channel_up_s=1 -> LINK_UP; retry_count=0.
  - Otherwise, when timer==UP_TIMEOUT_CYCLES-1 -> failure.
  - hard_err_s=1 -> failure immediately.
- LINK_UP: channel_up_s=0 or hard_err_s=1 -> drop_count+1, then failure.
- Failure handling: retry_count+1 (saturating).
  - If MAX_RETRIES!=0 and the new count >= MAX_RETRIES -> FAILED.
  - Otherwise -> HOLDOFF.
- HOLDOFF: when timer==HOLDOFF_CYCLES-1 -> GT_RST.
- FAILED: sticky; leaves only on force_retry, a falling-then-rising enable, or clk50_reset.
- Simultaneous events:
  - channel_up_s and timeout in the same cycle: channel_up wins -> LINK_UP.
  - channel_up_s and hard_err_s in the same cycle in WAIT_UP: hard_err wins -> failure.
- lane_up is synchronized and is used only for the optional feature.
- Counters saturate at all-ones and never wrap. drop_count and soft_err_count clear only on clk50_reset.

Optional Feature:
CHAN_LINK_SOFT_ERR_RESET_EN
- Defined: adds a window counter plus parameters SOFT_ERR_LIMIT (default 16) and SOFT_ERR_WINDOW (default 50000000).
- The window counter restarts on LINK_UP entry and at every window expiry.
- In LINK_UP, if SOFT_ERR_LIMIT soft_err edges occur within one window, the FSM treats it as a failure (drop_count+1, retry handling as above).
- Not defined: soft errors are only counted; no reset is caused.

Test Plan:
- Params GT=4, SYS=3, TIMEOUT=20, HOLDOFF=5, MAX=2. Release reset with channel_up=1 -> gt_reset_out high 4 cycles, system_reset_out high 7 cycles, link_ok=1 by cycle 10, retry_count=0.
- channel_up held 0 -> two timeouts with 5-cycle holdoff between them -> failed=1, fsm_state=6, retry_count=2, gt_reset_out=1; then a force_retry pulse -> GT_RST and retry_count=0.
- In LINK_UP, drop channel_up for 1 cycle -> drop_count=1, link_ok=0 within 3 cycles, HOLDOFF then a new GT_RST.
- In WAIT_UP, hard_err=1 and channel_up=1 in the same cycle -> failure, not LINK_UP.
- enable=0 mid-WAIT_UP -> DISABLED within 1 cycle, both resets high; enable=1 -> full sequence restarts.
- With the macro defined, LIMIT=3 and WINDOW=100: 3 soft_err pulses within 50 cycles -> LINK_UP exits and drop_count=1. Without the macro -> soft_err_count=3 and link_ok stays 1.

Source files
------------

// File: rtl/chan_link_reset_sequencer.sv
// Startup/retry reset sequencer for one Aurora 8b10b channel link, clk50 domain.
// Optional soft-error triggered relink is built when CHAN_LINK_SOFT_ERR_RESET_EN is defined.
module chan_link_reset_sequencer #(
    parameter int unsigned GT_RESET_CYCLES   = 50,
    parameter int unsigned SYS_RESET_CYCLES  = 16,
    parameter int unsigned UP_TIMEOUT_CYCLES = 5000000,
    parameter int unsigned HOLDOFF_CYCLES    = 500000,
    parameter int unsigned MAX_RETRIES       = 8,
    parameter int unsigned TIMER_W           = 32
`ifdef CHAN_LINK_SOFT_ERR_RESET_EN
    ,
    parameter int unsigned SOFT_ERR_LIMIT    = 16,
    parameter int unsigned SOFT_ERR_WINDOW   = 50000000
`endif
) (
    input  logic        clk50,
    input  logic        clk50_reset,
    input  logic        enable,
    input  logic        force_retry,
    input  logic        channel_up,
    input  logic        lane_up,
    input  logic        hard_err,
    input  logic        soft_err,
    output logic        gt_reset_out,
    output logic        system_reset_out,
    output logic        link_ok,
    output logic        failed,
    output logic [2:0]  fsm_state,
    output logic [7:0]  retry_count,
    output logic [15:0] drop_count,
    output logic [15:0] soft_err_count
);

    typedef enum logic [2:0] {
        DISABLED = 3'd0,
        GT_RST   = 3'd1,
        SYS_RST  = 3'd2,
        WAIT_UP  = 3'd3,
        LINK_UP  = 3'd4,
        HOLDOFF  = 3'd5,
        FAILED   = 3'd6
    } state_t;

    localparam logic [TIMER_W-1:0] GT_LAST   = TIMER_W'(GT_RESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SYS_LAST  = TIMER_W'(SYS_RESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0] UP_LAST   = TIMER_W'(UP_TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLDOFF_CYCLES - 1);

    // Synchronizer bit order: {soft_err, hard_err, lane_up, channel_up}
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic       soft_prev_q, soft_prev_d;
    logic       channel_up_s, lane_up_s, hard_err_s, soft_err_s, soft_edge;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               gt_reset_q, gt_reset_d;
    logic               sys_reset_q, sys_reset_d;
    logic               link_ok_q, link_ok_d;
    logic               failed_q, failed_d;
    logic [7:0]         retry_q, retry_d;
    logic [15:0]        drop_q, drop_d;
    logic [15:0]        sec_q, sec_d;

    logic       restart, fail, drop, clr_retry, retry_exhausted, soft_trip;
    logic [7:0] retry_inc;

    assign sync1_d      = {soft_err, hard_err, lane_up, channel_up};
    assign sync2_d      = sync1_q;
    assign channel_up_s = sync2_q[0];
    assign lane_up_s    = sync2_q[1];
    assign hard_err_s   = sync2_q[2];
    assign soft_err_s   = sync2_q[3];
    assign soft_prev_d  = soft_err_s;
    assign soft_edge    = soft_err_s & ~soft_prev_q;

    assign retry_inc       = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
    assign retry_exhausted = (MAX_RETRIES != 0) && (32'(retry_inc) >= MAX_RETRIES);

`ifdef CHAN_LINK_SOFT_ERR_RESET_EN
    localparam logic [TIMER_W-1:0] WIN_LAST  = TIMER_W'(SOFT_ERR_WINDOW - 1);
    localparam logic [TIMER_W-1:0] ERR_LIMIT = TIMER_W'(SOFT_ERR_LIMIT);

    logic [TIMER_W-1:0] win_timer_q, win_timer_d;
    logic [TIMER_W-1:0] win_errs_q, win_errs_d;
    logic [TIMER_W-1:0] win_seen;

    // Fixed windows aligned to LINK_UP entry; edges only count while the lanes are up.
    always_comb begin
        win_seen    = win_errs_q + TIMER_W'(soft_edge & lane_up_s);
        soft_trip   = (state_q == LINK_UP) && (win_seen >= ERR_LIMIT);
        win_timer_d = '0;
        win_errs_d  = '0;
        if (state_q == LINK_UP && win_timer_q != WIN_LAST) begin
            win_timer_d = win_timer_q + TIMER_W'(1);
            win_errs_d  = win_seen;
        end
    end

    always_ff @(posedge clk50) begin
        if (clk50_reset) begin
            win_timer_q <= '0;
            win_errs_q  <= '0;
        end else begin
            win_timer_q <= win_timer_d;
            win_errs_q  <= win_errs_d;
        end
    end
`else
    logic unused_lane_up;
    assign unused_lane_up = lane_up_s;
    assign soft_trip      = 1'b0;
`endif

    // State register plus registered outputs and counters
    always_ff @(posedge clk50) begin
        if (clk50_reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            soft_prev_q <= 1'b0;
            state_q     <= GT_RST;
            timer_q     <= '0;
            gt_reset_q  <= 1'b1;
            sys_reset_q <= 1'b1;
            link_ok_q   <= 1'b0;
            failed_q    <= 1'b0;
            retry_q     <= '0;
            drop_q      <= '0;
            sec_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            soft_prev_q <= soft_prev_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            gt_reset_q  <= gt_reset_d;
            sys_reset_q <= sys_reset_d;
            link_ok_q   <= link_ok_d;
            failed_q    <= failed_d;
            retry_q     <= retry_d;
            drop_q      <= drop_d;
            sec_q       <= sec_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        restart   = 1'b0;
        fail      = 1'b0;
        drop      = 1'b0;
        clr_retry = 1'b0;
        if (!enable) begin
            state_d = DISABLED;
        end else if (force_retry) begin
            state_d   = GT_RST;
            restart   = 1'b1;
            clr_retry = 1'b1;
        end else begin
            unique case (state_q)
                DISABLED: begin
                    state_d   = GT_RST;
                    clr_retry = 1'b1;
                end
                GT_RST:  if (timer_q == GT_LAST) state_d = SYS_RST;
                SYS_RST: if (timer_q == SYS_LAST) state_d = WAIT_UP;
                WAIT_UP: begin
                    if (hard_err_s) begin
                        fail = 1'b1;
                    end else if (channel_up_s) begin
                        state_d   = LINK_UP;
                        clr_retry = 1'b1;
                    end else if (timer_q == UP_LAST) begin
                        fail = 1'b1;
                    end
                end
                LINK_UP: begin
                    if (!channel_up_s || hard_err_s || soft_trip) begin
                        fail = 1'b1;
                        drop = 1'b1;
                    end
                end
                HOLDOFF: if (timer_q == HOLD_LAST) state_d = GT_RST;
                FAILED:  state_d = FAILED;
                default: state_d = GT_RST;
            endcase
            if (fail) state_d = retry_exhausted ? FAILED : HOLDOFF;
        end
    end

    // Timer and counters
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q || restart) begin
            timer_d = '0;
        end else if (state_q == GT_RST || state_q == SYS_RST ||
                     state_q == WAIT_UP || state_q == HOLDOFF) begin
            timer_d = timer_q + TIMER_W'(1);
        end

        retry_d = retry_q;
        if (clr_retry)  retry_d = '0;
        else if (fail)  retry_d = retry_inc;

        drop_d = drop_q;
        if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;

        sec_d = sec_q;
        if (soft_edge && sec_q != 16'hFFFF) sec_d = sec_q + 16'd1;
    end

    // Output decode from the next state so the registered outputs line up with state_q
    always_comb begin
        gt_reset_d  = 1'b1;
        sys_reset_d = 1'b1;
        link_ok_d   = 1'b0;
        failed_d    = 1'b0;
        unique case (state_d)
            SYS_RST: gt_reset_d = 1'b0;
            WAIT_UP: begin
                gt_reset_d  = 1'b0;
                sys_reset_d = 1'b0;
            end
            LINK_UP: begin
                gt_reset_d  = 1'b0;
                sys_reset_d = 1'b0;
                link_ok_d   = 1'b1;
            end
            FAILED:  failed_d = 1'b1;
            default: gt_reset_d = 1'b1;
        endcase
    end

    assign gt_reset_out     = gt_reset_q;
    assign system_reset_out = sys_reset_q;
    assign link_ok          = link_ok_q;
    assign failed           = failed_q;
    assign fsm_state        = state_q;
    assign retry_count      = retry_q;
    assign drop_count       = drop_q;
    assign soft_err_count   = sec_q;

endmodule

// File: tb/tb_chan_link_reset_sequencer.sv
// Bench for chan_link_reset_sequencer: directed scenarios then random stimulus,
// every cycle checked against a countdown-style reference model through an expected queue.
module tb_chan_link_reset_sequencer;

    localparam int GT    = 4;
    localparam int SYS   = 3;
    localparam int UPTO  = 20;
    localparam int HOLD  = 5;
    localparam int MAXR  = 2;
    localparam int W     = 47;
`ifdef CHAN_LINK_SOFT_ERR_RESET_EN
    localparam int LIMIT  = 3;
    localparam int WINDOW = 100;
`endif

    logic clk = 1'b0;
    logic r_rst, r_en, r_force, r_cu, r_lu, r_he, r_se;

    logic        dut_gt, dut_sys, dut_ok, dut_failed;
    logic [2:0]  dut_state;
    logic [7:0]  dut_retry;
    logic [15:0] dut_drop, dut_sec;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v, act_v;
    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_state, m_rem, m_retry, m_drop, m_sec;
    logic [3:0] m_s1, m_s2;
    logic m_soft_prev;
`ifdef CHAN_LINK_SOFT_ERR_RESET_EN
    int m_age, m_win_cnt;
`endif

    always #10 clk = ~clk;

    chan_link_reset_sequencer #(
        .GT_RESET_CYCLES(GT),
        .SYS_RESET_CYCLES(SYS),
        .UP_TIMEOUT_CYCLES(UPTO),
        .HOLDOFF_CYCLES(HOLD),
        .MAX_RETRIES(MAXR),
        .TIMER_W(32)
`ifdef CHAN_LINK_SOFT_ERR_RESET_EN
        ,
        .SOFT_ERR_LIMIT(LIMIT),
        .SOFT_ERR_WINDOW(WINDOW)
`endif
    ) dut (
        .clk50(clk),
        .clk50_reset(r_rst),
        .enable(r_en),
        .force_retry(r_force),
        .channel_up(r_cu),
        .lane_up(r_lu),
        .hard_err(r_he),
        .soft_err(r_se),
        .gt_reset_out(dut_gt),
        .system_reset_out(dut_sys),
        .link_ok(dut_ok),
        .failed(dut_failed),
        .fsm_state(dut_state),
        .retry_count(dut_retry),
        .drop_count(dut_drop),
        .soft_err_count(dut_sec)
    );

    function automatic int dur(input int st);
        case (st)
            1:       return GT;
            2:       return SYS;
            3:       return UPTO;
            5:       return HOLD;
            default: return 0;
        endcase
    endfunction

    // One clock of the behavioural model; pushes the outputs expected after this edge.
    task automatic model_step();
        logic cu, he, edge_s, trip, fail, drop;
        int nxt;
        logic gt, sys, ok, fl;
        if (r_rst) begin
            m_state = 1; m_rem = GT; m_retry = 0; m_drop = 0; m_sec = 0;
            m_s1 = '0; m_s2 = '0; m_soft_prev = 1'b0;
`ifdef CHAN_LINK_SOFT_ERR_RESET_EN
            m_age = 0; m_win_cnt = 0;
`endif
        end else begin
            cu = m_s2[0]; he = m_s2[2];
            edge_s = m_s2[3] && !m_soft_prev;
            trip = 1'b0; fail = 1'b0; drop = 1'b0;
`ifdef CHAN_LINK_SOFT_ERR_RESET_EN
            if (m_state == 4) begin
                if (edge_s && m_s2[1]) m_win_cnt++;
                trip = (m_win_cnt >= LIMIT);
                m_age++;
                if (m_age % WINDOW == 0) m_win_cnt = 0;
            end
`endif
            nxt = m_state;
            if (!r_en) nxt = 0;
            else if (r_force) begin
                nxt = 1; m_retry = 0;
            end else begin
                case (m_state)
                    0: begin nxt = 1; m_retry = 0; end
                    1: if (m_rem == 1) nxt = 2;
                    2: if (m_rem == 1) nxt = 3;
                    3: begin
                        if (he) fail = 1'b1;
                        else if (cu) begin nxt = 4; m_retry = 0; end
                        else if (m_rem == 1) fail = 1'b1;
                    end
                    4: if (!cu || he || trip) begin fail = 1'b1; drop = 1'b1; end
                    5: if (m_rem == 1) nxt = 1;
                    default: nxt = m_state;
                endcase
            end
            if (drop && m_drop < 65535) m_drop++;
            if (fail) begin
                if (m_retry < 255) m_retry++;
                nxt = (MAXR != 0 && m_retry >= MAXR) ? 6 : 5;
            end
            if (edge_s && m_sec < 65535) m_sec++;
            if (nxt != m_state || (r_en && r_force)) m_rem = dur(nxt);
            else m_rem--;
`ifdef CHAN_LINK_SOFT_ERR_RESET_EN
            if (nxt == 4 && m_state != 4) begin m_age = 0; m_win_cnt = 0; end
`endif
            m_state = nxt;
            m_soft_prev = m_s2[3];
            m_s2 = m_s1;
            m_s1 = {r_se, r_he, r_lu, r_cu};
        end
        gt  = (m_state == 0 || m_state == 1 || m_state == 5 || m_state == 6);
        sys = !(m_state == 3 || m_state == 4);
        ok  = (m_state == 4);
        fl  = (m_state == 6);
        exp_q.push_back({gt, sys, ok, fl, 3'(m_state), 8'(m_retry), 16'(m_drop), 16'(m_sec)});
    endtask

    always @(posedge clk) model_step();

    // Monitor: the DUT presents a fresh output set every cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {dut_gt, dut_sys, dut_ok, dut_failed, dut_state, dut_retry, dut_drop, dut_sec};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL outputs @%0t: got gt=%b sys=%b ok=%b failed=%b st=%0d retry=%0d drop=%0d soft=%0d, expected gt=%b sys=%b ok=%b failed=%b st=%0d retry=%0d drop=%0d soft=%0d",
                         $time, act_v[46], act_v[45], act_v[44], act_v[43], act_v[42:40], act_v[39:32], act_v[31:16], act_v[15:0],
                         exp_v[46], exp_v[45], exp_v[44], exp_v[43], exp_v[42:40], exp_v[39:32], exp_v[31:16], exp_v[15:0]);
            end
        end
    end

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_force();
        r_force = 1'b1;
        cycles(1);
        r_force = 1'b0;
    endtask

    initial begin
        r_rst = 1'b1; r_en = 1'b1; r_force = 1'b0;
        r_cu = 1'b1; r_lu = 1'b1; r_he = 1'b0; r_se = 1'b0;
        cycles(3);
        check_val("reset_state", dut_state, 1);
        check_val("reset_gt", dut_gt, 1);
        r_rst = 1'b0;
        cycles(10);
        check_val("startup_link_ok", dut_ok, 1);
        check_val("startup_retry", dut_retry, 0);

        // Lose the link and never get it back: ends in FAILED
        r_cu = 1'b0;
        cycles(150);
        check_val("failed_flag", dut_failed, 1);
        check_val("failed_state", dut_state, 6);
        check_val("failed_retry", dut_retry, 2);
        check_val("failed_gt", dut_gt, 1);
        check_val("first_drop", dut_drop, 1);

        r_cu = 1'b1;
        pulse_force();
        check_val("force_state", dut_state, 1);
        check_val("force_retry_clr", dut_retry, 0);
        cycles(15);
        check_val("relink_ok", dut_ok, 1);

        // One-cycle channel_up drop
        r_cu = 1'b0;
        cycles(1);
        r_cu = 1'b1;
        cycles(3);
        check_val("drop_link_ok", dut_ok, 0);
        check_val("drop_count", dut_drop, 2);
        cycles(25);

        // hard_err and channel_up together in WAIT_UP
        r_he = 1'b1;
        pulse_force();
        cycles(40);
        check_val("hard_err_state", dut_state, 6);
        check_val("hard_err_no_drop", dut_drop, 2);
        r_he = 1'b0;

        // Disable during WAIT_UP
        r_cu = 1'b0;
        pulse_force();
        cycles(9);
        check_val("pre_disable_state", dut_state, 3);
        r_en = 1'b0;
        cycles(1);
        check_val("disabled_state", dut_state, 0);
        check_val("disabled_gt", dut_gt, 1);
        check_val("disabled_sys", dut_sys, 1);
        cycles(4);
        r_en = 1'b1; r_cu = 1'b1;
        cycles(14);
        check_val("reenable_link_ok", dut_ok, 1);
        check_val("reenable_retry", dut_retry, 0);

        // Three soft error pulses inside one window
        for (int i = 0; i < 3; i++) begin
            r_se = 1'b1;
            cycles(1);
            r_se = 1'b0;
            cycles(3);
        end
        cycles(6);
        check_val("soft_err_count", dut_sec, 3);
`ifdef CHAN_LINK_SOFT_ERR_RESET_EN
        check_val("soft_trip_drop", dut_drop, 3);
        check_val("soft_trip_link", dut_ok, 0);
`else
        check_val("soft_no_drop", dut_drop, 2);
        check_val("soft_link_kept", dut_ok, 1);
`endif

        // Randomized stimulus
        for (int i = 0; i < 2500; i++) begin
            r_rst   = ($urandom_range(0, 299) == 0);
            if (r_en) r_en = ($urandom_range(0, 149) != 0);
            else      r_en = ($urandom_range(0, 4) == 0);
            r_force = ($urandom_range(0, 119) == 0);
            if ($urandom_range(0, 39) == 0) r_cu = ~r_cu;
            r_lu    = ($urandom_range(0, 19) != 0);
            r_he    = ($urandom_range(0, 199) == 0);
            r_se    = ($urandom_range(0, 7) == 0);
            cycles(1);
        end
        r_rst = 1'b0; r_force = 1'b0; r_he = 1'b0; r_se = 1'b0;
        cycles(3);
        #1;
        check_val("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
